// File: rtl/lipsi_pkg.sv
// Shared definitions for the Lipsi program loader.
//
// Holds the loader state encoding, the default program-memory address width,
// the width of the length byte, and small helpers used by the loader.
// The CHK state only exists when LOADER_CHECKSUM_EN is defined.
package lipsi_pkg;

  // Default program-memory address width (2**8 = 256 bytes of program store).
  localparam int LIPSI_ADDR_W = 8;

  // Width of the length byte that prefixes every load.
  localparam int LEN_W = 8;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_ERROR = 3'd3
`ifdef LOADER_CHECKSUM_EN
    ,
    ST_CHK   = 3'd4
`endif
  } loader_state_e;

  // True for the states in which the loader takes bytes from the stream.
  function automatic logic state_accepts(input loader_state_e s);
    logic acc;
    case (s)
      ST_LEN:  acc = 1'b1;
      ST_LOAD: acc = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:  acc = 1'b1;
`endif
      default: acc = 1'b0;
    endcase
    return acc;
  endfunction

  // Running checksum step: 8-bit sum modulo 256.
  function automatic logic [LEN_W-1:0] csum_add(input logic [LEN_W-1:0] acc,
                                                input logic [LEN_W-1:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/lipsi_loader.sv
// Lipsi program loader.
//
// Receives a byte stream (length byte, payload, optional checksum byte),
// writes the payload into program memory starting at address 0 and then
// releases the Lipsi core from hold.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   ena        - design selected; low freezes the loader, ld_ready forced low
//   ld_data    - loader byte stream
//   ld_valid   - ld_data valid
//   ld_ready   - loader can accept a byte
//   mem_we     - program-memory write strobe (one cycle per payload byte)
//   mem_addr   - program-memory write address (held while mem_we is low)
//   mem_wdata  - program-memory write data (held while mem_we is low)
//   core_run   - core released; high only in RUN
//   err        - load failed; high only in ERROR
//
// Build option: define LOADER_CHECKSUM_EN to expect a trailing checksum byte
// (8-bit sum of the payload). A mismatch ends in ERROR. Without the macro
// there is no checksum state and err is constant 0.
module lipsi_loader
  import lipsi_pkg::*;
#(
  parameter int ADDR_W = LIPSI_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_run,
  output logic              err
);

  loader_state_e      state_r;
  loader_state_e      state_next_s;
  logic [LEN_W-1:0]   count_r;
  logic [ADDR_W-1:0]  addr_r;
  logic               ready_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [7:0]         mem_wdata_r;
  logic               core_run_r;
  logic               accept_s;

`ifdef LOADER_CHECKSUM_EN
  logic [LEN_W-1:0]   csum_r;
  logic               err_r;
`endif

  // ready_r is registered from the next state so ld_ready drops on the same
  // edge that enters RUN/ERROR; ena gates it combinationally.
  assign ld_ready = ena & ready_r;
  assign accept_s = ena & ld_valid & ready_r;

  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign core_run  = core_run_r;
`ifdef LOADER_CHECKSUM_EN
  assign err       = err_r;
`else
  assign err       = 1'b0;
`endif

  // State register; ena low freezes the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LEN;
    end else if (ena) begin
      state_r <= state_next_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Next-state logic; only an accepted byte moves the FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_LEN: begin
        if (accept_s) begin
          if (ld_data == 8'd0) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_LOAD: begin
        if (accept_s && (count_r == 8'd1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_next_s = ST_CHK;
`else
          state_next_s = ST_RUN;
`endif
        end else begin
          state_next_s = state_r;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept_s) begin
          if (ld_data == csum_r) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_ERROR;
          end
        end else begin
          state_next_s = state_r;
        end
      end
`endif
      ST_RUN:   state_next_s = ST_RUN;
      ST_ERROR: state_next_s = ST_ERROR;
      default:  state_next_s = ST_LEN;
    endcase
  end

  // Datapath: length counter, address counter, write port and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= {LEN_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
      ready_r     <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 8'd0;
      core_run_r  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_r      <= {LEN_W{1'b0}};
      err_r       <= 1'b0;
`endif
    end else begin
      // The strobe is a single-cycle pulse: a pulse issued just before ena
      // drops still completes, and no new one starts without an accept.
      mem_we_r <= 1'b0;
      if (accept_s) begin
        case (state_r)
          ST_LEN: begin
            count_r <= ld_data;
            addr_r  <= {ADDR_W{1'b0}};
`ifdef LOADER_CHECKSUM_EN
            csum_r  <= {LEN_W{1'b0}};
`endif
          end
          ST_LOAD: begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= addr_r;
            mem_wdata_r <= ld_data;
            addr_r      <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            count_r     <= count_r - 8'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_r      <= csum_add(csum_r, ld_data);
`endif
          end
          default: begin
            count_r <= count_r;
          end
        endcase
      end
      if (ena) begin
        ready_r    <= state_accepts(state_next_s);
        core_run_r <= (state_r == ST_RUN);
`ifdef LOADER_CHECKSUM_EN
        err_r      <= (state_r == ST_ERROR);
`endif
      end
    end
  end

endmodule

// File: tb/tb_lipsi_loader.sv
// Self-checking bench for lipsi_loader: directed scenarios with a write
// scoreboard. Expected (addr, data) pairs are queued as payload bytes are
// driven; a negedge monitor pops and compares on every mem_we pulse.
module tb_lipsi_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ld_data = 8'd0;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       core_run;
  logic       err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];

  lipsi_loader #(.ADDR_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .ld_data  (ld_data),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .core_run (core_run),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", {31'd0, mem_we}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
      end
    end
  end

  // Drive one byte and hold it until an edge with ld_ready high consumes it.
  // Returns #1 after the consuming edge, ld_valid still high.
  task automatic send_byte(input logic [7:0] b, input string tag);
    int k = 0;
    ld_data  = b;
    ld_valid = 1'b1;
    while (!(ld_ready && ena) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      check({tag, "_ready_timeout"}, {31'd0, ld_ready}, 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_payload(input logic [7:0] a, input logic [7:0] d, input string tag);
    exp_q.push_back({a, d});
    send_byte(d, tag);
  endtask

  task automatic apply_reset();
    ld_valid = 1'b0;
    ena      = 1'b1;
    rst_n    = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_drained(input string tag);
    repeat (2) @(negedge clk);
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    logic [7:0] d;
    logic [7:0] sum;

    // Reset state with inputs active.
    ena = 1'b1;
    ld_valid = 1'b1;
    ld_data = 8'h5C;
    #3;
    check("rst_ready",    {31'd0, ld_ready}, 32'd0);
    check("rst_we",       {31'd0, mem_we},   32'd0);
    check("rst_addr",     {24'd0, mem_addr}, 32'd0);
    check("rst_wdata",    {24'd0, mem_wdata}, 32'd0);
    check("rst_core_run", {31'd0, core_run}, 32'd0);
    check("rst_err",      {31'd0, err},      32'd0);

    // LEN(3) with back-to-back payload.
    apply_reset();
    send_byte(8'd3, "s1_len");
    t0 = cyc;
    send_payload(8'd0, 8'h11, "s1_b0");
    send_payload(8'd1, 8'h22, "s1_b1");
    send_payload(8'd2, 8'h33, "s1_b2");
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h66, "s1_chk");
    t1 = cyc;
    check("s1_no_bubble", t1 - t0, 32'd4);
`else
    t1 = cyc;
    check("s1_no_bubble", t1 - t0, 32'd3);
    check("s1_last_we", {31'd0, mem_we}, 32'd1);
`endif
    ld_valid = 1'b0;
    check("s1_ready_low", {31'd0, ld_ready}, 32'd0);
    check("s1_run_not_yet", {31'd0, core_run}, 32'd0);
    @(posedge clk); #1;
    check("s1_core_run", {31'd0, core_run}, 32'd1);
    check("s1_ready_run", {31'd0, ld_ready}, 32'd0);
    check("s1_we_idle", {31'd0, mem_we}, 32'd0);
    expect_drained("s1_drained");

    // LEN(0): straight to RUN, no writes.
    apply_reset();
    send_byte(8'd0, "s2_len");
    ld_valid = 1'b0;
    check("s2_ready_low", {31'd0, ld_ready}, 32'd0);
    check("s2_run_not_yet", {31'd0, core_run}, 32'd0);
    @(posedge clk); #1;
    check("s2_core_run", {31'd0, core_run}, 32'd1);
    check("s2_err", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    check("s2_run_terminal", {31'd0, core_run}, 32'd1);

    // LEN(2) with ena dropped for 3 cycles mid-stream.
    apply_reset();
    send_byte(8'd2, "s3_len");
    send_payload(8'd0, 8'hA5, "s3_b0");
    ena = 1'b0;
    ld_data = 8'h5A;
    #1;
    check("s3_ready_ena_low", {31'd0, ld_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3_no_accept", {31'd0, ld_ready}, 32'd0);
    end
    check("s3_hold_addr", {24'd0, mem_addr}, 32'd0);
    check("s3_hold_wdata", {24'd0, mem_wdata}, 32'h0000_00A5);
    ena = 1'b1;
    ld_valid = 1'b0;
    @(negedge clk);
    check("s3_ready_back", {31'd0, ld_ready}, 32'd1);
    send_payload(8'd1, 8'h5A, "s3_b1");
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hFF, "s3_chk");
`endif
    ld_valid = 1'b0;
    @(posedge clk); #1;
    check("s3_core_run", {31'd0, core_run}, 32'd1);
    expect_drained("s3_drained");

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch.
    apply_reset();
    send_byte(8'd2, "s4_len");
    send_payload(8'd0, 8'h10, "s4_b0");
    send_payload(8'd1, 8'h20, "s4_b1");
    send_byte(8'h30, "s4_chk");
    ld_valid = 1'b0;
    @(posedge clk); #1;
    check("s4_core_run", {31'd0, core_run}, 32'd1);
    check("s4_err", {31'd0, err}, 32'd0);
    expect_drained("s4_drained");

    apply_reset();
    send_byte(8'd2, "s4b_len");
    send_payload(8'd0, 8'h10, "s4b_b0");
    send_payload(8'd1, 8'h20, "s4b_b1");
    send_byte(8'h31, "s4b_chk");
    ld_valid = 1'b0;
    @(posedge clk); #1;
    check("s4b_err", {31'd0, err}, 32'd1);
    check("s4b_core_run", {31'd0, core_run}, 32'd0);
    check("s4b_ready", {31'd0, ld_ready}, 32'd0);
    expect_drained("s4b_drained");
`endif

    // Reset pulsed after 1 of 4 payload bytes, then a fresh LEN(1) load.
    apply_reset();
    send_byte(8'd4, "s5_len");
    send_payload(8'd0, 8'hC3, "s5_b0");
    ld_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_rst_ready", {31'd0, ld_ready}, 32'd0);
    check("s5_rst_we",    {31'd0, mem_we},   32'd0);
    check("s5_rst_addr",  {24'd0, mem_addr}, 32'd0);
    check("s5_rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("s5_rst_run",   {31'd0, core_run}, 32'd0);
    check("s5_rst_err",   {31'd0, err},      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'd1, "s5_len2");
    send_payload(8'd0, 8'hAA, "s5_b0b");
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hAA, "s5_chk");
`endif
    ld_valid = 1'b0;
    @(posedge clk); #1;
    check("s5_core_run", {31'd0, core_run}, 32'd1);
    expect_drained("s5_drained");

    // LEN(255), incrementing pattern, no wrap.
    apply_reset();
    sum = 8'd0;
    send_byte(8'd255, "s6_len");
    for (int i = 0; i < 255; i++) begin
      d = 8'(i + 1);
      sum = sum + d;
      send_payload(8'(i), d, "s6_b");
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum, "s6_chk");
`endif
    ld_valid = 1'b0;
    @(posedge clk); #1;
    check("s6_core_run", {31'd0, core_run}, 32'd1);
    expect_drained("s6_drained");
    check("s6_last_addr", {24'd0, mem_addr}, 32'd254);
    check("s6_last_wdata", {24'd0, mem_wdata}, 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
